hamming_enc: RTL and testbench
==============================

Name: hamming_enc

Overview:
- Upstream neighbour of the Hamming (21,16) decoder. Accepts 16-bit words and buffers them in a small FIFO.
- Encodes each word into a 21-bit codeword with 5 parity bits at indices 0,1,3,7,15, using the layout the decoder expects.
- Emits each codeword as a single-cycle valid pulse followed by a mandatory idle gap. The decoder is rising-edge triggered on valid, so back-to-back words would be lost.
- Optional single-bit error injection exercises the decoder's correction path.

Parameters:
- FIFO_DEPTH, 4: input FIFO entries; power of two, >= 2.
- GAP_CYCLES, 2: idle cycles forced between output pulses; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- iData  in  16  data word to encode.
- iValid  in  1  iData present; pushed when iValid && oReady.
- oReady  out  1  FIFO not full.
- oData  out  21  codeword; stable from the oValid pulse until the next launch.
- oValid  out  1  one-cycle pulse per codeword.
- iReady  in  1  downstream may accept a launch.
- iInjEn  in  1  flip one codeword bit on the next launch.
- iInjPos  in  5  bit index to flip; values >= 21 mean no flip.
- oCount  out  16  number of codewords emitted; wraps modulo 2^16.

Behaviour:
- Reset (async, immediate): oValid=0, oData=0, oCount=0, FIFO empty, oReady=1, state IDLE, gap counter 0. Reset asserted mid-transfer drops all buffered words; there is no partial output.
- Data mapping: cw[2]=d[0], cw[6:4]=d[3:1], cw[14:8]=d[10:4], cw[20:16]=d[15:11].
- Parity bits (combinational from the FIFO head):
  - cw[0] = XOR of cw[2,4,6,8,10,12,14,16,18,20]
  - cw[1] = XOR of cw[2,5,6,9,10,13,14,17,18]
  - cw[3] = XOR of cw[4,5,6,11,12,13,14,19,20]
  - cw[7] = XOR of cw[14:8]
  - cw[15] = XOR of cw[20:16]
- FIFO:
  - Write pointer, read pointer, and an occupancy count of log2(FIFO_DEPTH)+1 bits; both pointers wrap naturally.
  - oReady = count < FIFO_DEPTH; it is combinational from the registered count.
  - A push while full is blocked by oReady; iValid is ignored in that case.
  - Simultaneous push and pop leave count unchanged. This includes pushing while full in the same cycle as a pop: oReady stays 0 that cycle, so the push is not taken.
- State machine:
  - IDLE: if FIFO not empty && iReady, then launch. oData <= encoded head (with injection applied), oValid <= 1, pop the FIFO, oCount++, go to SEND.
  - SEND: oValid <= 0, gap counter <= GAP_CYCLES-1, go to GAP.
  - GAP: on counter == 0 go to IDLE, otherwise decrement.
- Timing:
  - Launch latency: a word pushed into an empty FIFO with iReady=1 appears on oValid/oData 2 cycles after the push edge (one cycle registers the FIFO write, one registers the output).
  - Minimum spacing between oValid pulses: GAP_CYCLES+1 idle cycles.
  - iReady is sampled only in IDLE; deasserting it in SEND or GAP has no effect on the current word.
- Injection:
  - iInjEn and iInjPos are sampled on the launch cycle only.
  - If iInjEn=1 and iInjPos < 21, bit iInjPos of the launched codeword is inverted.
  - Parity is computed before the flip.
- oData holds its last value between pulses and is not cleared after SEND.

Decomposition:
- Shared package hamming_pkg holds:
  - CW_W=21, DATA_W=16;
  - the parity index constants 0,1,3,7,15;
  - a function ham_encode(16b) -> 21b.
- The decoder should reuse the same constants.
- One sub-module, hamming_fifo: parameterised synchronous FIFO with async reset, providing push/pop/full/empty/count. The encode datapath and FSM stay in the top.

Test Plan:
- Reset then push 16'h0000 with iReady=1 -> one oValid pulse 2 cycles after the push, oData=21'h000000, oCount=1.
- Push 16'h0001, 16'hFFFF, 16'h8000 back-to-back -> oData 21'h000007, 21'h1FFFFE, 21'h108009 in order, each a 1-cycle pulse separated by >= GAP_CYCLES+1 idle cycles.
- Hold iReady=0 and push 5 words with FIFO_DEPTH=4 -> oReady drops after the 4th push, the 5th is refused, no oValid. Then release iReady -> exactly 4 pulses, and oReady returns high after the first launch.
- Push 16'h0001 with iInjEn=1, iInjPos=5 at launch -> oData=21'h000027. Repeat with iInjPos=21 -> oData=21'h000007.
- Assert rst while in GAP with 2 words queued -> outputs return to reset values immediately, and no further pulses occur after rst deasserts.
- Loopback into the decoder with random data and random iInjPos in 0..20 -> decoded data equals the original on every word.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (21,16) encoder/decoder pair.
//   CW_W / DATA_W   : codeword and data widths
//   PAR_IDX*        : codeword indices that carry parity bits
//   state_t         : encoder launch state machine states
//   ham_encode()    : maps 16 data bits into the 21-bit codeword and fills parity
package hamming_pkg;

  localparam int CW_W   = 21;
  localparam int DATA_W = 16;

  // Parity bits sit at power-of-two positions (1-based 1,2,4,8,16).
  localparam int PAR_IDX0 = 0;
  localparam int PAR_IDX1 = 1;
  localparam int PAR_IDX2 = 3;
  localparam int PAR_IDX3 = 7;
  localparam int PAR_IDX4 = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [CW_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    cw        = '0;
    cw[2]     = d[0];
    cw[6:4]   = d[3:1];
    cw[14:8]  = d[10:4];
    cw[20:16] = d[15:11];
    cw[PAR_IDX0] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14]
                 ^ cw[16] ^ cw[18] ^ cw[20];
    cw[PAR_IDX1] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14]
                 ^ cw[17] ^ cw[18];
    cw[PAR_IDX2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14]
                 ^ cw[19] ^ cw[20];
    cw[PAR_IDX3] = ^cw[14:8];
    cw[PAR_IDX4] = ^cw[20:16];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Synchronous FIFO with asynchronous active-high reset.
//   clk, rst        : clock, async reset (empties the FIFO)
//   push, wrData    : write request and data (ignored while full)
//   pop, rdData     : read request (ignored while empty); rdData shows the head
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
module hamming_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = mem[rdPtr];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, so resetting the array only costs logic.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_enc.sv
// Hamming (21,16) encoder feeding the single-pulse decoder.
//   clk, rst        : clock, async active-high reset
//   iData, iValid   : input word, accepted when iValid && oReady
//   oReady          : input FIFO has space
//   oData, oValid   : codeword and its one-cycle launch pulse; oData holds
//                     until the next launch
//   iReady          : downstream may accept a launch (sampled in IDLE only)
//   iInjEn, iInjPos : invert codeword bit iInjPos on the next launch (<21 only)
//   oCount          : codewords emitted, wraps at 2^16
module hamming_enc
  import hamming_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic [CW_W-1:0]   oData,
  output logic              oValid,
  input  logic              iReady,
  input  logic              iInjEn,
  input  logic [4:0]        iInjPos,
  output logic [15:0]       oCount
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [GW-1:0]    GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [GW-1:0]    GAP_ONE   = 1;
  localparam logic [4:0]       POS_LIMIT = 5'(CW_W);

  logic [DATA_W-1:0] headData;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              push;
  logic              launch;

  state_t            state;
  state_t            stateNext;
  logic [GW-1:0]     gapCnt;
  logic [GW-1:0]     gapCntNext;
  logic              oValidNext;

  logic [CW_W-1:0]   headCw;
  logic [CW_W-1:0]   injMask;
  logic [CW_W-1:0]   launchCw;

  assign oReady = (fifoCount < CNT_DEPTH);
  assign push   = iValid && !fifoFull;

  hamming_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .wrData (iData),
    .pop    (launch),
    .rdData (headData),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  // Parity is formed on the clean word; the optional flip is applied after.
  assign headCw   = ham_encode(headData);
  assign injMask  = (iInjEn && (iInjPos < POS_LIMIT)) ? (CW_W'(1) << iInjPos) : '0;
  assign launchCw = headCw ^ injMask;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    stateNext  = state;
    gapCntNext = gapCnt;
    oValidNext = 1'b0;
    launch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty && iReady) begin
          launch     = 1'b1;
          oValidNext = 1'b1;
          stateNext  = SEND;
        end
      end
      SEND: begin
        gapCntNext = GAP_LOAD;
        stateNext  = GAP;
      end
      GAP: begin
        if (gapCnt == '0) stateNext  = IDLE;
        else              gapCntNext = gapCnt - GAP_ONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gapCnt <= '0;
      oValid <= 1'b0;
      oData  <= '0;
      oCount <= '0;
    end else begin
      state  <= stateNext;
      gapCnt <= gapCntNext;
      oValid <= oValidNext;
      if (launch) begin
        oData  <= launchCw;
        oCount <= oCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_enc.sv
// Scoreboard bench for hamming_enc: stimulus pushes expected codewords into a
// queue; a negedge monitor pops and compares on every oValid pulse and also
// checks pulse width, pulse spacing, oCount, oData hold and a reference decode.
module tb_hamming_enc;

  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] iData = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [20:0] oData;
  logic        oValid;
  logic        iReady = 1'b0;
  logic        iInjEn = 1'b0;
  logic [4:0]  iInjPos = '0;
  logic [15:0] oCount;

  hamming_enc #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .iData   (iData),
    .iValid  (iValid),
    .oReady  (oReady),
    .oData   (oData),
    .oValid  (oValid),
    .iReady  (iReady),
    .iInjEn  (iInjEn),
    .iInjPos (iInjPos),
    .oCount  (oCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [20:0] cw;
  } exp_t;

  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  int   cyc = 0;
  int   pulseCnt = 0;
  int   lastPulseCyc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model written from the Hamming definition (1-based position
  // p is a parity bit when p is a power of two; it covers positions with bit k set).
  function automatic logic [20:0] modelEnc(input logic [15:0] d);
    logic [20:0] cw;
    int k;
    cw = '0;
    k = 0;
    for (int i = 0; i < 21; i++) begin
      if ((((i + 1) & i)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int p = 0; p < 5; p++) begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < 21; i++)
        if ((((i + 1) >> p) & 1) == 1 && i != (1 << p) - 1) b = b ^ cw[i];
      cw[(1 << p) - 1] = b;
    end
    return cw;
  endfunction

  function automatic logic [15:0] modelDec(input logic [20:0] cwIn);
    logic [20:0] cw;
    logic [15:0] d;
    int syn;
    int k;
    cw = cwIn;
    syn = 0;
    for (int i = 0; i < 21; i++) if (cw[i]) syn = syn ^ (i + 1);
    if (syn != 0 && syn <= 21) cw[syn - 1] = ~cw[syn - 1];
    d = '0;
    k = 0;
    for (int i = 0; i < 21; i++) begin
      if ((((i + 1) & i)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor / scoreboard.
  initial begin
    logic        prevValid;
    logic [20:0] lastData;
    int          expCount;
    exp_t        e;
    prevValid = 1'b0;
    lastData  = '0;
    expCount  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevValid    = 1'b0;
        lastData     = '0;
        expCount     = 0;
        lastPulseCyc = -100;
      end else if (oValid) begin
        check("pulse_width", 32'(prevValid), 32'd0);
        check("pulse_spacing_ok", 32'(cyc - lastPulseCyc >= GAP_CYCLES + 2), 32'd1);
        lastPulseCyc = cyc;
        expCount++;
        check("oCount", 32'(oCount), 32'(expCount[15:0]));
        if (expQ.size() == 0) begin
          check("unexpected_pulse_queue", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          check("oData", 32'(oData), 32'(e.cw));
          check("decoded", 32'(modelDec(oData)), 32'(e.data));
        end
        lastData  = oData;
        prevValid = 1'b1;
        pulseCnt++;
      end else begin
        check("oData_hold", 32'(oData), 32'(lastData));
        prevValid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word (caller has checked oReady) and record its expected codeword.
  task automatic pushWord(input logic [15:0] d, input logic [20:0] cw);
    exp_t e;
    iData  = d;
    iValid = 1'b1;
    e.data = d;
    e.cw   = cw;
    expQ.push_back(e);
    tick();
    iValid = 1'b0;
  endtask

  task automatic waitPulses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulseCnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_pulse_arrived"}, 32'(pulseCnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int driveCyc;

    // Reset state.
    #2;
    check("rst_oValid", 32'(oValid), 32'd0);
    check("rst_oData",  32'(oData),  32'd0);
    check("rst_oCount", 32'(oCount), 32'd0);
    check("rst_oReady", 32'(oReady), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single word: latency and value.
    iReady = 1'b1;
    driveCyc = cyc;
    pushWord(16'h0000, 21'h000000);
    waitPulses(1, 20, "first");
    check("launch_latency", 32'(lastPulseCyc - driveCyc), 32'd2);
    repeat (5) tick();

    // Back-to-back pushes, spaced pulses.
    pushWord(16'h0001, 21'h000007);
    pushWord(16'hFFFF, 21'h1FFFFE);
    pushWord(16'h8000, 21'h108009);
    waitPulses(4, 40, "b2b");
    repeat (5) tick();

    // Fill with downstream stalled; 5th push refused.
    iReady = 1'b0;
    base = pulseCnt;
    for (int i = 0; i < 5; i++) begin
      check("oReady_before_push", 32'(oReady), 32'(i < FIFO_DEPTH));
      if (i < FIFO_DEPTH) begin
        case (i)
          0: pushWord(16'h0000, 21'h000000);
          1: pushWord(16'h0001, 21'h000007);
          2: pushWord(16'hFFFF, 21'h1FFFFE);
          default: pushWord(16'h8000, 21'h108009);
        endcase
      end else begin
        iData  = 16'h1234;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
      end
    end
    repeat (8) tick();
    check("stalled_no_pulse", 32'(pulseCnt), 32'(base));
    iReady = 1'b1;
    waitPulses(base + 1, 20, "release");
    check("oReady_after_launch", 32'(oReady), 32'd1);
    waitPulses(base + 4, 60, "drain");
    repeat (10) tick();
    check("drain_exact_pulses", 32'(pulseCnt), 32'(base + 4));
    check("drain_queue_empty", 32'(expQ.size()), 32'd0);

    // Error injection: in-range flip, then out-of-range position.
    iInjEn  = 1'b1;
    iInjPos = 5'd5;
    base = pulseCnt;
    pushWord(16'h0001, 21'h000027);
    waitPulses(base + 1, 20, "inj5");
    repeat (4) tick();
    iInjPos = 5'd21;
    pushWord(16'h0001, 21'h000007);
    waitPulses(base + 2, 20, "inj21");
    repeat (4) tick();
    iInjEn = 1'b0;

    // Reset asserted during GAP with two words still queued.
    base = pulseCnt;
    iData  = 16'h0000;
    iValid = 1'b1;
    begin
      exp_t e;
      e.data = 16'h0000;
      e.cw   = 21'h000000;
      expQ.push_back(e);
    end
    tick();
    iData = 16'h0001;
    tick();
    iData = 16'hFFFF;
    waitPulses(base + 1, 20, "pre_reset");
    tick();
    iValid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_oValid", 32'(oValid), 32'd0);
    check("midrst_oData",  32'(oData),  32'd0);
    check("midrst_oCount", 32'(oCount), 32'd0);
    check("midrst_oReady", 32'(oReady), 32'd1);
    expQ.delete();
    tick();
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("post_reset_no_pulse", 32'(pulseCnt), 32'(base + 1));

    // Loopback: random words with a random single-bit flip, decoded by the model.
    iInjEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] d;
      logic [4:0]  pos;
      d   = 16'($urandom);
      pos = 5'($urandom_range(0, 20));
      iInjPos = pos;
      base = pulseCnt;
      pushWord(d, modelEnc(d) ^ (21'd1 << pos));
      waitPulses(base + 1, 20, "loopback");
      repeat (4) tick();
    end
    iInjEn = 1'b0;

    check("final_queue_empty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
